// File: rtl/iot_monitor_multi.sv
// iot_monitor_multi
//   Multi-channel active-device monitor. Each of CHANNELS device groups has
//   its own up/down counter that steps once per cycle while change[i] is high,
//   upward when on_off[i]=1 and downward when on_off[i]=0. The counters either
//   saturate (WRAP=0) or wrap modulo 2^WIDTH (WRAP=1). They also keep sticky
//   overflow/underflow flags and a per-channel threshold alarm. A registered
//   grand total of all channels is also kept.
//
// Ports
//   clk          system clock, all state on the rising edge
//   rst          asynchronous active-low reset
//   clear        synchronous clear of counters, total and error flags
//   change       per-channel event strobe (one event per high cycle)
//   on_off       per-channel direction, 1 = +1, 0 = -1
//   threshold    shared alarm level (combinational compare)
//   counter_out  flattened counts, channel i at [i*WIDTH +: WIDTH]
//   total_out    sum of the counts as they stood one cycle earlier
//   over_thresh  count[i] >= threshold
//   ovf_err      sticky: increment attempted at the maximum count
//   unf_err      sticky: decrement attempted at zero
module iot_monitor_multi #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int WRAP     = 0,
  // A single channel still gets one extra bit so the total has headroom.
  parameter int TW       = WIDTH + ((CHANNELS > 1) ? $clog2(CHANNELS) : 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic [CHANNELS-1:0]       change,
  input  logic [CHANNELS-1:0]       on_off,
  input  logic [WIDTH-1:0]          threshold,
  output logic [CHANNELS*WIDTH-1:0] counter_out,
  output logic [TW-1:0]             total_out,
  output logic [CHANNELS-1:0]       over_thresh,
  output logic [CHANNELS-1:0]       ovf_err,
  output logic [CHANNELS-1:0]       unf_err
);

  localparam logic [WIDTH-1:0] MAX_COUNT = '1;

  logic [CHANNELS-1:0][WIDTH-1:0] counts;
  logic [TW-1:0]                  sum_next;
  logic [TW-1:0]                  total_reg;

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic [WIDTH-1:0] count_reg;
      logic             ovf_reg;
      logic             unf_reg;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          count_reg <= '0;
          ovf_reg   <= 1'b0;
          unf_reg   <= 1'b0;
        end else if (clear) begin
          // clear wins over any event on the same edge, including the error it
          // would otherwise have raised.
          count_reg <= '0;
          ovf_reg   <= 1'b0;
          unf_reg   <= 1'b0;
        end else if (change[gi]) begin
          if (on_off[gi]) begin
            if (count_reg == MAX_COUNT) begin
              ovf_reg <= 1'b1;
              if (WRAP != 0) count_reg <= '0;
            end else begin
              count_reg <= count_reg + WIDTH'(1);
            end
          end else begin
            if (count_reg == '0) begin
              unf_reg <= 1'b1;
              if (WRAP != 0) count_reg <= MAX_COUNT;
            end else begin
              count_reg <= count_reg - WIDTH'(1);
            end
          end
        end
      end

      assign counts[gi]                        = count_reg;
      assign counter_out[gi*WIDTH +: WIDTH]    = count_reg;
      assign over_thresh[gi]                   = (count_reg >= threshold);
      assign ovf_err[gi]                       = ovf_reg;
      assign unf_err[gi]                       = unf_reg;
    end
  endgenerate

  // Zero-extended sum of the current counter registers; TW is sized so this
  // cannot overflow even with every channel at its maximum.
  always_comb begin
    sum_next = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      sum_next = sum_next + {{(TW-WIDTH){1'b0}}, counts[i]};
    end
  end

  // Registering the pre-edge sum makes total_out lag counter_out by one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      total_reg <= '0;
    end else if (clear) begin
      total_reg <= '0;
    end else begin
      total_reg <= sum_next;
    end
  end

  assign total_out = total_reg;

endmodule

// File: tb/tb_iot_monitor_multi.sv
// Bench for iot_monitor_multi: a saturating (WRAP=0) and a wrapping (WRAP=1)
// instance share one stimulus stream and are compared every cycle against a
// plain integer model of the counting rules. A few hand-computed literals pin
// the directed scenarios.
module tb_iot_monitor_multi;
  localparam int W   = 8;
  localparam int CH  = 4;
  localparam int TWB = W + $clog2(CH);
  localparam int MAXV = (1 << W) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear = 1'b0;
  logic [CH-1:0] change = '0;
  logic [CH-1:0] on_off = '0;
  logic [W-1:0]  threshold = '0;

  logic [CH*W-1:0] co  [2];
  logic [TWB-1:0]  tot [2];
  logic [CH-1:0]   ot  [2];
  logic [CH-1:0]   ovf [2];
  logic [CH-1:0]   unf [2];

  int tests = 0;
  int fails = 0;

  // model state, index [mode][channel], mode 0 = saturate, 1 = wrap
  int m_cnt [2][CH];
  bit m_ovf [2][CH];
  bit m_unf [2][CH];
  int m_tot [2];

  iot_monitor_multi #(.WIDTH(W), .CHANNELS(CH), .WRAP(0)) dut_sat (
    .clk(clk), .rst(rst), .clear(clear), .change(change), .on_off(on_off),
    .threshold(threshold), .counter_out(co[0]), .total_out(tot[0]),
    .over_thresh(ot[0]), .ovf_err(ovf[0]), .unf_err(unf[0]));

  iot_monitor_multi #(.WIDTH(W), .CHANNELS(CH), .WRAP(1)) dut_wrap (
    .clk(clk), .rst(rst), .clear(clear), .change(change), .on_off(on_off),
    .threshold(threshold), .counter_out(co[1]), .total_out(tot[1]),
    .over_thresh(ot[1]), .ovf_err(ovf[1]), .unf_err(unf[1]));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_zero();
    for (int m = 0; m < 2; m++) begin
      m_tot[m] = 0;
      for (int i = 0; i < CH; i++) begin
        m_cnt[m][i] = 0; m_ovf[m][i] = 0; m_unf[m][i] = 0;
      end
    end
  endtask

  // One rising edge worth of the counting rules, using the inputs the DUT saw.
  task automatic model_edge();
    if (!rst || clear) begin
      model_zero();
      return;
    end
    for (int m = 0; m < 2; m++) begin
      int s = 0;
      for (int i = 0; i < CH; i++) s += m_cnt[m][i];
      m_tot[m] = s;
      for (int i = 0; i < CH; i++) begin
        if (change[i]) begin
          if (on_off[i]) begin
            if (m_cnt[m][i] == MAXV) begin
              m_ovf[m][i] = 1;
              m_cnt[m][i] = (m == 1) ? 0 : MAXV;
            end else m_cnt[m][i]++;
          end else begin
            if (m_cnt[m][i] == 0) begin
              m_unf[m][i] = 1;
              m_cnt[m][i] = (m == 1) ? MAXV : 0;
            end else m_cnt[m][i]--;
          end
        end
      end
    end
  endtask

  task automatic compare_all(input string tag);
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("%s m%0d total_out", tag, m), 64'(tot[m]), 64'(m_tot[m]));
      for (int i = 0; i < CH; i++) begin
        chk($sformatf("%s m%0d ch%0d count", tag, m, i), 64'(co[m][i*W +: W]), 64'(m_cnt[m][i]));
        chk($sformatf("%s m%0d ch%0d over_thresh", tag, m, i), 64'(ot[m][i]),
            64'(m_cnt[m][i] >= int'(threshold)));
        chk($sformatf("%s m%0d ch%0d ovf_err", tag, m, i), 64'(ovf[m][i]), 64'(m_ovf[m][i]));
        chk($sformatf("%s m%0d ch%0d unf_err", tag, m, i), 64'(unf[m][i]), 64'(m_unf[m][i]));
      end
    end
  endtask

  // every-cycle compare, away from the active edge
  always @(negedge clk) compare_all("cyc");

  // Apply inputs, take one edge, update the model; returns 1 time unit after
  // the edge so the next inputs never race the edge.
  task automatic cycle(input logic clr, input logic [CH-1:0] chg,
                       input logic [CH-1:0] oo);
    clear = clr; change = chg; on_off = oo;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic repeat_cycles(input int n, input logic [CH-1:0] chg,
                               input logic [CH-1:0] oo);
    for (int k = 0; k < n; k++) cycle(1'b0, chg, oo);
  endtask

  // Assert reset between edges and check outputs before the next edge.
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b0;
    model_zero();
    #1;
    chk({tag, " async rst counter_out"}, 64'(co[0]), 64'd0);
    chk({tag, " async rst total_out"}, 64'(tot[0]), 64'd0);
    compare_all({tag, " async rst"});
    @(posedge clk);
    model_edge();
    #1;
    rst = 1'b1;
  endtask

  initial begin
    model_zero();
    #1 rst = 1'b0;
    threshold = '0;
    // reset held with events pending
    repeat_cycles(3, '1, '1);
    chk("reset counter_out", 64'(co[0]), 64'd0);
    chk("reset ovf/unf", 64'({ovf[0], unf[0]}), 64'd0);
    chk("reset over_thresh thr=0", 64'(ot[0]), 64'hF);
    rst = 1'b1;
    threshold = 8'd200;

    // count to 5 then reset asynchronously mid-cycle
    repeat_cycles(5, '1, '1);
    chk("pre-reset ch2", 64'(co[0][2*W +: W]), 64'd5);
    async_reset("mid");

    // up/down on ch0
    repeat_cycles(10, 4'b0001, 4'b0001);
    repeat_cycles(3, 4'b0001, 4'b0000);
    chk("updown counter_out", 64'(co[0]), 64'd7);
    repeat_cycles(1, '0, '0);
    chk("updown total_out", 64'(tot[0]), 64'd7);

    // parallel channels
    cycle(1'b1, '0, '0);
    repeat_cycles(4, 4'b1111, 4'b1111);
    repeat_cycles(3, 4'b1111, 4'b0101);
    chk("parallel counts", 64'(co[0]), 64'({8'd1, 8'd7, 8'd1, 8'd7}));
    repeat_cycles(1, '0, '0);
    chk("parallel total", 64'(tot[0]), 64'd16);

    // limits: ch1 to max, then overflow ch1 and underflow ch2 together
    cycle(1'b1, '0, '0);
    repeat_cycles(255, 4'b0010, 4'b0010);
    chk("ch1 at max", 64'(co[0][W +: W]), 64'd255);
    cycle(1'b0, 4'b0110, 4'b0010);
    chk("sat ch1 holds", 64'(co[0][W +: W]), 64'd255);
    chk("wrap ch1 to 0", 64'(co[1][W +: W]), 64'd0);
    chk("sat ch2 holds 0", 64'(co[0][2*W +: W]), 64'd0);
    chk("wrap ch2 to max", 64'(co[1][2*W +: W]), 64'd255);
    repeat_cycles(20, '0, '0);
    chk("sat ovf sticky", 64'(ovf[0]), 64'b0010);
    chk("sat unf sticky", 64'(unf[0]), 64'b0100);
    chk("wrap ovf sticky", 64'(ovf[1]), 64'b0010);
    chk("wrap unf sticky", 64'(unf[1]), 64'b0100);

    // threshold and clear priority
    cycle(1'b1, '0, '0);
    threshold = 8'd3;
    repeat_cycles(3, 4'b1000, 4'b1000);
    chk("thresh reached", 64'(ot[0][3]), 64'd1);
    chk("thresh others", 64'(ot[0][2:0]), 64'd0);
    cycle(1'b1, 4'b1000, 4'b1000);
    chk("clear ch3", 64'(co[0][3*W +: W]), 64'd0);
    chk("clear over_thresh", 64'(ot[0][3]), 64'd0);
    chk("clear total", 64'(tot[0]), 64'd0);
    chk("clear flags", 64'({ovf[0], unf[0], ovf[1], unf[1]}), 64'd0);
    // clear together with an underflowing event raises no flag
    cycle(1'b1, 4'b1111, 4'b0000);
    chk("clear vs unf", 64'(unf[0]), 64'd0);

    // randomized phases biased up or down to reach both limits
    for (int k = 0; k < 3000; k++) begin
      logic [CH-1:0] chg;
      logic [CH-1:0] oo;
      int p;
      p = ((k / 300) % 2 == 0) ? 85 : 15;
      chg = CH'($urandom);
      for (int i = 0; i < CH; i++) oo[i] = ($urandom_range(99) < p);
      if (k % 50 == 0) threshold = W'($urandom);
      cycle(($urandom_range(399) == 0), chg, oo);
      if (k % 997 == 500) async_reset("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
